// File: rtl/soc_system_pll_ctrl_pkg.sv
// ============================================================================
// soc_system_pll_ctrl_pkg : shared types, defaults and elaboration checks
// Rev 1.0
// ============================================================================
`default_nettype none

package soc_system_pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } pll_ctrl_state_t;

  localparam int DEF_RST_PULSE_CYCLES    = 16;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
  localparam int DEF_MAX_RETRIES         = 3;
  localparam int DEF_CNT_W               = 16;
  localparam int DEF_RETRY_W             = 2;

  // The counter only ever has to reach (longest interval - 1).
  function automatic bit pll_ctrl_widths_ok(input int cnt_w, input int retry_w,
                                            input int rst_pulse, input int lock_stable,
                                            input int lock_timeout, input int max_retries);
    longint max_cnt;
    max_cnt = longint'(rst_pulse);
    if (longint'(lock_stable) > max_cnt) max_cnt = longint'(lock_stable);
    if (longint'(lock_timeout) > max_cnt) max_cnt = longint'(lock_timeout);
    return (rst_pulse >= 1) && (lock_stable >= 1) && (lock_timeout >= 1) &&
           ((max_cnt - 1) < (longint'(1) << cnt_w)) &&
           (longint'(max_retries) < (longint'(1) << retry_w));
  endfunction

endpackage

`default_nettype wire

// File: rtl/soc_system_sync2.sv
// ============================================================================
// soc_system_sync2 : generic 2-flop synchronizer, asynchronous reset to 0
// Rev 1.0
// ============================================================================
`default_nettype none

module soc_system_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      q      <= '0;
    end else begin
      r_meta <= d;
      q      <= r_meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/soc_system_pll_reset_ctrl.sv
// ============================================================================
// soc_system_pll_reset_ctrl : PLL reset sequencer and lock supervisor
// Rev 1.0
// ============================================================================
`default_nettype none

module soc_system_pll_reset_ctrl
  import soc_system_pll_ctrl_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int CNT_W               = DEF_CNT_W,
  parameter int RETRY_W             = DEF_RETRY_W
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               relock_req,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               ready,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_count
);

  localparam logic [CNT_W-1:0]   C_RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   C_STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   C_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] C_MAX_RETRIES  = RETRY_W'(MAX_RETRIES);

  if (!pll_ctrl_widths_ok(CNT_W, RETRY_W, RST_PULSE_CYCLES, LOCK_STABLE_CYCLES,
                          LOCK_TIMEOUT_CYCLES, MAX_RETRIES)) begin : g_width_check
    $error("soc_system_pll_reset_ctrl: CNT_W or RETRY_W too small for the parameters");
  end

  pll_ctrl_state_t   state;
  pll_ctrl_state_t   state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [RETRY_W-1:0] retry_nxt;
  logic              lock_s;
  logic              restart;

  soc_system_sync2 #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  always_comb begin
    state_nxt = state;
    retry_nxt = retry_count;
    if (relock_req) begin
      state_nxt = ST_RESET_PLL;
      retry_nxt = '0;
    end else begin
      case (state)
        ST_RESET_PLL: if (cnt == C_RST_LAST) state_nxt = ST_WAIT_LOCK;
        ST_WAIT_LOCK: begin
          // A lock seen on the timeout cycle wins over the retry.
          if (lock_s) begin
            state_nxt = ST_STABLE;
          end else if (cnt == C_TIMEOUT_LAST) begin
            if (retry_count < C_MAX_RETRIES) begin
              state_nxt = ST_RESET_PLL;
              retry_nxt = retry_count + RETRY_W'(1);
            end else begin
              state_nxt = ST_FAULT;
            end
          end
        end
        ST_STABLE: begin
          if (!lock_s)                    state_nxt = ST_WAIT_LOCK;
          else if (cnt == C_STABLE_LAST)  state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_nxt = ST_RESET_PLL;
            retry_nxt = '0;
          end
        end
        ST_FAULT: state_nxt = ST_FAULT;
        default:  state_nxt = ST_RESET_PLL;
      endcase
    end
  end

  // relock_req from RESET_PLL keeps the state but still restarts the pulse.
  assign restart = relock_req || (state_nxt != state);

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state       <= ST_RESET_PLL;
      cnt         <= '0;
      retry_count <= '0;
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_nxt;
      retry_count <= retry_nxt;
      if (restart)
        cnt <= '0;
      else if (state != ST_RUN && state != ST_FAULT)
        cnt <= cnt + CNT_W'(1);
      pll_rst <= (state_nxt == ST_RESET_PLL) || (state_nxt == ST_FAULT);
      sys_rst <= (state_nxt != ST_RUN);
      ready   <= (state_nxt == ST_RUN);
      fault   <= (state_nxt == ST_FAULT);
    end
  end

endmodule

`default_nettype wire

// File: doc/soc_system_pll_reset_ctrl.md
# soc_system_pll_reset_ctrl

Reset sequencer and lock supervisor for the SoC PLL that produces the 100 MHz AES/AXI clocks. Runs on the free-running 50 MHz reference clock. Pulses the PLL reset, waits for a stable lock, retries on timeout, and holds the downstream system reset until the PLL output is trustworthy. On lock loss it re-sequences automatically and reports faults to software.

## Interface
- RST_PULSE_CYCLES, 16: refclk cycles pll_rst is held high per attempt (≥1)
- LOCK_STABLE_CYCLES, 1024: consecutive locked cycles required before release (≥1)
- LOCK_TIMEOUT_CYCLES, 65536: max cycles in WAIT_LOCK per attempt
- MAX_RETRIES, 3: extra attempts after the first before FAULT
- CNT_W, 16: shared cycle-counter width; must hold max(parameter)−1
- RETRY_W, 2: retry_count width; must hold MAX_RETRIES
- refclk  in  1  the single clock, 50 MHz reference, free-running
- rst  in  1  asynchronous, active-high reset
- pll_locked  in  1  PLL lock, asynchronous to refclk
- relock_req  in  1  single-cycle request to restart sequencing, refclk domain
- pll_rst  out  1  PLL reset, active-high
- sys_rst  out  1  downstream reset, active-high
- ready  out  1  PLL locked and stable; equals ~sys_rst
- fault  out  1  retries exhausted
- retry_count  out  RETRY_W  retries used in the current sequence

## Operation
- pll_locked passes through a 2-flop synchronizer (lock_s); the FSM sees only lock_s.
- States: RESET_PLL, WAIT_LOCK, STABLE, RUN, FAULT. One shared counter is cleared on every state change.
- RESET_PLL: pll_rst=1, sys_rst=1. After RST_PULSE_CYCLES cycles -> WAIT_LOCK.
- WAIT_LOCK: pll_rst=0, sys_rst=1.
  - lock_s=1 -> STABLE.
  - Else, when counter = LOCK_TIMEOUT_CYCLES−1: if retry_count < MAX_RETRIES, increment retry_count and go to RESET_PLL; otherwise go to FAULT.
- STABLE: pll_rst=0, sys_rst=1.
  - lock_s=0 -> WAIT_LOCK. The timeout restarts; this is not a retry.
  - lock_s=1 with counter = LOCK_STABLE_CYCLES−1 -> RUN.
- RUN: pll_rst=0, sys_rst=0, ready=1. lock_s=0 -> RESET_PLL and clear retry_count.
- FAULT: pll_rst=1, sys_rst=1, fault=1. The only exits are relock_req and rst.
- relock_req in any state -> RESET_PLL, with retry_count and fault cleared.
- Simultaneous events:
  - relock_req beats every other transition.
  - In WAIT_LOCK, lock_s=1 beats timeout.
  - In RUN, lock loss together with relock_req gives the identical result.
- retry_count saturates at MAX_RETRIES. It holds its value through RUN until the next clear.

## Timing
- Reset values (also the state during rst): state RESET_PLL, counter 0, synchronizer flops 0, pll_rst=1, sys_rst=1, ready=0, fault=0, retry_count=0.
- rst asserted mid-sequence returns every output to its reset value asynchronously. No glitch on sys_rst: it is already high or goes high.
- All outputs are registered and computed from the next state, so they change on the same edge as the state.
- After rst deasserts, pll_rst stays high for exactly RST_PULSE_CYCLES refclk edges.
- Lock to release: if edge k first samples pll_locked high, lock_s is high after edge k+1, STABLE is entered at edge k+2, and sys_rst falls / ready rises at edge k+2+LOCK_STABLE_CYCLES.
- Lock loss in RUN: sys_rst and pll_rst rise 2 edges after pll_locked is first sampled low.
- Lock loss is detected within 3 refclk cycles.
- Pulses on pll_locked shorter than one refclk period may be missed. This is acceptable.

## Structure
- Package soc_system_pll_ctrl_pkg holds:
  - the state enum (pll_ctrl_state_t)
  - the default parameter constants
  - a width check function that flags CNT_W or RETRY_W too small during elaboration
- Sub-module soc_system_sync2: a generic 2-flop synchronizer with asynchronous reset to 0, reused for other async status inputs.
- The FSM, counter and retry logic stay in the top module.

## Test plan
Bench parameters: RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2.
- Clean bring-up: release rst, raise pll_locked 10 cycles later. Required: pll_rst high for exactly 4 edges, ready=1 and sys_rst=0 at edge k+10, retry_count=0.
- Lock glitch in STABLE: drop pll_locked for 3 cycles at cycle 4 of STABLE. Required: return to WAIT_LOCK, 8-cycle stable count restarts, retry_count stays 0.
- Timeout and retries: hold pll_locked=0. Required: 3 pll_rst pulses of 4 cycles separated by 32-cycle waits, retry_count 0→1→2, then fault=1 with pll_rst=1 and sys_rst=1.
- Recovery from FAULT: pulse relock_req. Required: fault=0, retry_count=0, new 4-cycle pll_rst pulse; lock then releases normally.
- Lock loss in RUN: drop pll_locked. Required: sys_rst=1, ready=0 and pll_rst=1 2 edges later; automatic re-sequence to RUN.
- Async reset mid-STABLE and simultaneous events:
  - assert rst mid-STABLE: all outputs return to reset values immediately
  - in WAIT_LOCK, lock_s rising on the timeout cycle: goes to STABLE, not a retry
